// File: rtl/spi_arbiter_pkg.sv
// spi_arbiter_pkg: shared types and defaults for the SPI master arbiter.
// State encoding, requester ids, timing defaults, round-robin picker.
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_XFER,
    ST_HOLD,
    ST_LOCKED
  } state_e;

  localparam int REQ_CPU    = 0;
  localparam int REQ_ENGINE = 1;

  localparam int CS_SETUP_DEF  = 2;
  localparam int CS_HOLD_DEF   = 2;
  localparam int START_TMO_DEF = 255;

  // Index of the winner; on contention the one that did not go last.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       last
  );
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between a CPU (0) and an engine (1).
// Ports: raw_clk/reset_n; req/req_width16/req_lock/req_tx0/req_tx1 from
// requesters; done/err/rx_data/grant/cs_n back to them; spi_start/
// spi_width16/spi_tx to the master; spi_busy/spi_rx from the master.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int CS_SETUP  = CS_SETUP_DEF,
  parameter int CS_HOLD   = CS_HOLD_DEF,
  parameter int START_TMO = START_TMO_DEF
) (
  input  logic        raw_clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_width16,
  input  logic [1:0]  req_lock,
  input  logic [15:0] req_tx0,
  input  logic [15:0] req_tx1,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rx_data,
  output logic [1:0]  grant,
  output logic [1:0]  cs_n,
  output logic        spi_start,
  output logic        spi_width16,
  output logic [15:0] spi_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  cs_n_q, cs_n_d;
  logic        start_q, start_d;
  logic        w16_q, w16_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        lock_q, lock_d;
  logic        last_q, last_d;

  logic        owner;
  logic        pick;
  logic        cnt_one;
  logic        tmo_hit;
  logic [15:0] tx_pick;
  logic [15:0] tx_own;

  assign owner   = grant_q[1];
  assign pick    = rr_pick(req, last_q);
  assign cnt_one = (cnt_q == 8'd1);
  // cnt counts START cycles already spent without busy
  assign tmo_hit = (cnt_q == 8'(START_TMO - 1));
  assign tx_pick = pick ? req_tx1 : req_tx0;
  assign tx_own  = owner ? req_tx1 : req_tx0;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      grant_q <= 2'b00;
      cs_n_q  <= 2'b11;
      start_q <= 1'b0;
      w16_q   <= 1'b0;
      tx_q    <= 16'd0;
      rx_q    <= 8'd0;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      cs_n_q  <= cs_n_d;
      start_q <= start_d;
      w16_q   <= w16_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (|req) state_d = ST_SETUP;
      ST_SETUP:
        if (cnt_one) state_d = ST_START;
      ST_START:
        if (spi_busy) state_d = ST_XFER;
        else if (tmo_hit) state_d = ST_IDLE;
      ST_XFER:
        if (!spi_busy) state_d = ST_HOLD;
      ST_HOLD:
        if (cnt_one) state_d = lock_q ? ST_LOCKED : ST_IDLE;
      ST_LOCKED:
        if (req[owner]) state_d = ST_START;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    grant_d = grant_q;
    cs_n_d  = cs_n_q;
    start_d = start_q;
    w16_d   = w16_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    done_d  = 2'b00;
    err_d   = 1'b0;
    lock_d  = lock_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE:
        if (|req) begin
          grant_d = pick ? 2'b10 : 2'b01;
          cs_n_d  = pick ? 2'b01 : 2'b10;
          tx_d    = tx_pick;
          w16_d   = req_width16[pick];
          lock_d  = req_lock[pick];
          cnt_d   = 8'(CS_SETUP);
        end
      ST_SETUP:
        if (cnt_one) begin
          start_d = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      ST_START:
        if (spi_busy) begin
          start_d = 1'b0;
        end else if (tmo_hit) begin
          start_d       = 1'b0;
          cs_n_d        = 2'b11;
          grant_d       = 2'b00;
          done_d[owner] = 1'b1;
          err_d         = 1'b1;
          lock_d        = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      ST_XFER:
        if (!spi_busy) begin
          rx_d  = spi_rx;
          cnt_d = 8'(CS_HOLD);
        end
      ST_HOLD:
        if (cnt_one) begin
          done_d[owner] = 1'b1;
          last_d        = owner;
          if (!lock_q) begin
            cs_n_d  = 2'b11;
            grant_d = 2'b00;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      ST_LOCKED:
        // burst continuation: cs already low, skip setup
        if (req[owner]) begin
          tx_d    = tx_own;
          w16_d   = req_width16[owner];
          lock_d  = req_lock[owner];
          start_d = 1'b1;
          cnt_d   = 8'd0;
        end
      default: begin
        cs_n_d  = 2'b11;
        grant_d = 2'b00;
        start_d = 1'b0;
      end
    endcase
  end

  assign done        = done_q;
  assign err         = err_q;
  assign rx_data     = rx_q;
  assign grant       = grant_q;
  assign cs_n        = cs_n_q;
  assign spi_start   = start_q;
  assign spi_width16 = w16_q;
  assign spi_tx      = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized self-checking bench for spi_arbiter.
// Behavioural SPI master plus a request-level arbitration model.
module tb_spi_arbiter;

  localparam int PER = 10;

  logic        raw_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_width16 = 2'b00;
  logic [1:0]  req_lock = 2'b00;
  logic [15:0] req_tx0 = 16'd0;
  logic [15:0] req_tx1 = 16'd0;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rx_data;
  logic [1:0]  grant;
  logic [1:0]  cs_n;
  logic        spi_start;
  logic        spi_width16;
  logic [15:0] spi_tx;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_rx = 8'd0;

  int errors = 0;
  int checks = 0;
  int mdl_last = 1;

  int          mst_cnt = 0;
  int          mst_len = 0;
  bit          mst_dead = 0;
  bit          rx_fix_en = 0;
  logic [7:0]  rx_fix = 8'd0;
  logic [7:0]  cur_rx = 8'd0;
  logic [15:0] cap_tx = 16'd0;
  logic        cap_w = 1'b0;
  time         fall_t = 0;
  bit          viol_cs = 0;
  bit          viol_start = 0;

  spi_arbiter dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .req(req),
    .req_width16(req_width16), .req_lock(req_lock),
    .req_tx0(req_tx0), .req_tx1(req_tx1), .done(done), .err(err),
    .rx_data(rx_data), .grant(grant), .cs_n(cs_n),
    .spi_start(spi_start), .spi_width16(spi_width16),
    .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_rx(spi_rx)
  );

  always #(PER / 2) raw_clk = ~raw_clk;

  // SPI master model: busy follows start, rx valid only once busy drops
  always @(negedge raw_clk) begin
    if (!reset_n) begin
      spi_busy = 1'b0;
      mst_cnt  = 0;
    end else if (spi_busy) begin
      if (mst_cnt <= 1) begin
        spi_busy = 1'b0;
        spi_rx   = cur_rx;
        fall_t   = $time;
      end else begin
        mst_cnt--;
      end
    end else if (spi_start && !mst_dead) begin
      spi_busy = 1'b1;
      mst_cnt  = (mst_len > 0) ? mst_len : int'($urandom_range(1, 6));
      cur_rx   = rx_fix_en ? rx_fix : 8'($urandom);
      spi_rx   = ~cur_rx;
      cap_tx   = spi_tx;
      cap_w    = spi_width16;
    end
  end

  always @(negedge raw_clk) begin
    if (cs_n === 2'b00) viol_cs = 1;
    if (spi_start === 1'b1 && cs_n === 2'b11) viol_start = 1;
  end

  initial begin
    #(PER * 50000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int mdl_pick(input logic [1:0] p, input int last);
    if (p == 2'b11) return 1 - last;
    return p[1] ? 1 : 0;
  endfunction

  task automatic wait_done(input int budget, output logic [1:0] d,
                           output int n, output bit ok);
    n = 0; ok = 0; d = 2'b00;
    while (n < budget) begin
      @(negedge raw_clk);
      n++;
      if (done !== 2'b00) begin
        d = done; ok = 1;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge raw_clk);
    req = 2'b00; req_lock = 2'b00;
    reset_n = 1'b0;
    repeat (3) @(negedge raw_clk);
    reset_n = 1'b1;
    mdl_last = 1;
    @(negedge raw_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge raw_clk);
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++; if (cs_n !== 2'b11) begin errors++;
      $display("FAIL rst_cs_n got=%b exp=11", cs_n); end
    checks++; if (spi_start !== 1'b0) begin errors++;
      $display("FAIL rst_start got=%b exp=0", spi_start); end
    checks++; if (done !== 2'b00 || err !== 1'b0) begin errors++;
      $display("FAIL rst_done got=%b/%b exp=00/0", done, err); end
    checks++; if (rx_data !== 8'd0) begin errors++;
      $display("FAIL rst_rx got=%h exp=00", rx_data); end
    checks++; if (spi_tx !== 16'd0 || spi_width16 !== 1'b0) begin
      errors++;
      $display("FAIL rst_tx got=%h/%b exp=0000/0", spi_tx, spi_width16);
    end
    reset_n = 1'b1;
    mdl_last = 1;
    repeat (2) @(negedge raw_clk);
    checks++; if (grant !== 2'b00 || cs_n !== 2'b11) begin errors++;
      $display("FAIL idle_out got=%b/%b exp=00/11", grant, cs_n); end
  endtask

  task automatic test_single();
    int n, cs_at, lat; logic [1:0] d; bit ok;
    req_tx0 = 16'h00A5; req_width16 = 2'b00; req_lock = 2'b00;
    rx_fix_en = 1; rx_fix = 8'h3C; mst_len = 4;
    req = 2'b01;
    n = 0; cs_at = -1;
    while (n < 20 && spi_start !== 1'b1) begin
      @(negedge raw_clk);
      n++;
      if (cs_n === 2'b10 && cs_at < 0) cs_at = n;
    end
    checks++; if (n != 3) begin errors++;
      $display("FAIL req_to_start got=%0d exp=3", n); end
    checks++; if (n - cs_at != 2) begin errors++;
      $display("FAIL cs_setup got=%0d exp=2", n - cs_at); end
    checks++; if (grant !== 2'b01) begin errors++;
      $display("FAIL single_grant got=%b exp=01", grant); end
    wait_done(100, d, n, ok);
    lat = int'(($time - fall_t) / PER);
    checks++; if (!ok || d !== 2'b01) begin errors++;
      $display("FAIL single_done got=%b exp=01", d); end
    checks++; if (rx_data !== 8'h3C || err !== 1'b0) begin errors++;
      $display("FAIL single_rx got=%h/%b exp=3c/0", rx_data, err); end
    checks++; if (cap_tx !== 16'h00A5 || cap_w !== 1'b0) begin errors++;
      $display("FAIL single_tx got=%h/%b exp=00a5/0", cap_tx, cap_w); end
    checks++; if (lat != 3) begin errors++;
      $display("FAIL busy_to_done got=%0d exp=3", lat); end
    req = 2'b00; mdl_last = 0;
    @(negedge raw_clk);
    checks++; if (done !== 2'b00 || cs_n !== 2'b11 || grant !== 2'b00)
    begin errors++;
      $display("FAIL single_after got=%b/%b/%b exp=00/11/00",
               done, cs_n, grant);
    end
    rx_fix_en = 0; mst_len = 0;
  endtask

  task automatic test_arbitration(input int rounds, input bit rnd);
    logic [1:0] pend, d, w; logic [15:0] tx [2]; int ex, n; bit ok;
    rx_fix_en = 0; mst_len = 0; viol_cs = 0; viol_start = 0;
    for (int k = 0; k < rounds; k++) begin
      pend = rnd ? 2'($urandom_range(1, 3)) : 2'b11;
      tx[0] = 16'($urandom); tx[1] = 16'($urandom); w = 2'($urandom);
      req_tx0 = tx[0]; req_tx1 = tx[1]; req_width16 = w;
      req_lock = 2'b00; req = pend;
      while (pend != 2'b00) begin
        ex = mdl_pick(pend, mdl_last);
        wait_done(300, d, n, ok);
        checks++; if (d !== 2'(1 << ex)) begin errors++;
          $display("FAIL arb_owner got=%b exp=%b", d, 2'(1 << ex)); end
        checks++; if (err !== 1'b0 || rx_data !== cur_rx) begin errors++;
          $display("FAIL arb_rx got=%h/%b exp=%h/0", rx_data, err, cur_rx);
        end
        checks++; if (cap_tx !== tx[ex] || cap_w !== w[ex]) begin errors++;
          $display("FAIL arb_tx got=%h/%b exp=%h/%b",
                   cap_tx, cap_w, tx[ex], w[ex]);
        end
        req[ex] = 1'b0; pend[ex] = 1'b0; mdl_last = ex;
        if (!ok) pend = 2'b00;
      end
      @(negedge raw_clk);
      checks++; if (grant !== 2'b00 || cs_n !== 2'b11) begin errors++;
        $display("FAIL arb_idle got=%b/%b exp=00/11", grant, cs_n); end
    end
    checks++; if (viol_cs || viol_start) begin errors++;
      $display("FAIL arb_cs_rules got=%b%b exp=00", viol_cs, viol_start);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    test_arbitration(2, 1'b0);
  endtask

  task automatic test_lock();
    int n, st_n; bit cs_hi, g0; logic [15:0] txv, tx0v; logic wv;
    logic [1:0] d; bit ok;
    txv = 16'($urandom); wv = 1'($urandom); tx0v = 16'($urandom);
    req_tx1 = txv; req_width16 = {wv, 1'b0}; req_lock = 2'b10;
    req = 2'b10;
    n = 0;
    while (grant !== 2'b10 && n < 20) begin
      @(negedge raw_clk); n++;
    end
    checks++; if (grant !== 2'b10) begin errors++;
      $display("FAIL lock_grant got=%b exp=10", grant); end
    req_tx0 = tx0v; req[0] = 1'b1;
    cs_hi = 0; g0 = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0; st_n = -1;
      do begin
        @(negedge raw_clk); n++;
        if (done === 2'b00) begin
          if (cs_n[1] !== 1'b0) cs_hi = 1;
          if (grant[0] === 1'b1) g0 = 1;
        end
        if (spi_start === 1'b1 && st_n < 0) st_n = n;
      end while (done === 2'b00 && n < 300);
      checks++; if (done !== 2'b10 || err !== 1'b0) begin errors++;
        $display("FAIL lock_done%0d got=%b/%b exp=10/0", i, done, err); end
      checks++; if (rx_data !== cur_rx || cap_tx !== txv || cap_w !== wv)
      begin errors++;
        $display("FAIL lock_data%0d got=%h/%h exp=%h/%h",
                 i, rx_data, cap_tx, cur_rx, txv);
      end
      checks++; if (grant !== ((i < 3) ? 2'b10 : 2'b00)) begin errors++;
        $display("FAIL lock_keep%0d got=%b", i, grant); end
      if (i > 0) begin
        checks++; if (st_n != 1) begin errors++;
          $display("FAIL lock_nosetup%0d got=%0d exp=1", i, st_n); end
      end
      if (i < 3) begin
        txv = 16'($urandom); wv = 1'($urandom);
        req_tx1 = txv; req_width16[1] = wv;
        req_lock[1] = (i < 2);
      end else begin
        req[1] = 1'b0; req_lock = 2'b00;
      end
    end
    mdl_last = 1;
    checks++; if (cs_hi || g0) begin errors++;
      $display("FAIL lock_burst got=cs_hi%b/g0%b exp=0/0", cs_hi, g0); end
    wait_done(300, d, n, ok);
    checks++; if (d !== 2'b01 || cap_tx !== tx0v) begin errors++;
      $display("FAIL lock_release got=%b/%h exp=01/%h", d, cap_tx, tx0v);
    end
    req[0] = 1'b0; mdl_last = 0;
    @(negedge raw_clk);
  endtask

  task automatic test_timeout();
    int n; logic [1:0] d; bit ok;
    mst_dead = 1;
    req_tx0 = 16'($urandom); req_lock = 2'b00; req = 2'b01;
    n = 0;
    while (spi_start !== 1'b1 && n < 20) begin
      @(negedge raw_clk); n++;
    end
    wait_done(400, d, n, ok);
    checks++; if (n != 255) begin errors++;
      $display("FAIL tmo_cycles got=%0d exp=255", n); end
    checks++; if (d !== 2'b01 || err !== 1'b1) begin errors++;
      $display("FAIL tmo_done got=%b/%b exp=01/1", d, err); end
    checks++; if (cs_n !== 2'b11 || grant !== 2'b00 || spi_start !== 1'b0)
    begin errors++;
      $display("FAIL tmo_out got=%b/%b/%b exp=11/00/0",
               cs_n, grant, spi_start);
    end
    req = 2'b00; mst_dead = 0;
    @(negedge raw_clk);
    checks++; if (done !== 2'b00 || err !== 1'b0) begin errors++;
      $display("FAIL tmo_pulse got=%b/%b exp=00/0", done, err); end
  endtask

  task automatic test_reset_mid();
    int n; bit nd; logic [1:0] d; bit ok; logic [15:0] txv;
    mst_len = 8;
    req_tx0 = 16'($urandom); req = 2'b01;
    n = 0;
    while (spi_start !== 1'b1 && n < 20) begin
      @(negedge raw_clk); n++;
    end
    repeat (2) @(negedge raw_clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cs_n !== 2'b11 || spi_start !== 1'b0 || grant !== 2'b00)
    begin errors++;
      $display("FAIL mid_reset got=%b/%b/%b exp=11/0/00",
               cs_n, spi_start, grant);
    end
    req = 2'b00; nd = 0;
    if (done !== 2'b00) nd = 1;
    repeat (3) begin
      @(negedge raw_clk);
      if (done !== 2'b00) nd = 1;
    end
    reset_n = 1'b1; mdl_last = 1; mst_len = 0;
    @(negedge raw_clk);
    if (done !== 2'b00) nd = 1;
    checks++; if (nd) begin errors++;
      $display("FAIL mid_nodone got=1 exp=0"); end
    txv = 16'($urandom);
    req_tx1 = txv; req_width16 = 2'b10; req = 2'b10;
    wait_done(300, d, n, ok);
    checks++; if (d !== 2'b10 || err !== 1'b0 || rx_data !== cur_rx)
    begin errors++;
      $display("FAIL mid_next got=%b/%b/%h exp=10/0/%h",
               d, err, rx_data, cur_rx);
    end
    checks++; if (cap_tx !== txv || cap_w !== 1'b1) begin errors++;
      $display("FAIL mid_tx got=%h/%b exp=%h/1", cap_tx, cap_w, txv); end
    req = 2'b00; mdl_last = 1;
    @(negedge raw_clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_arbitration(12, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
